rv32_branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters for the RV32IM core front end. It predicts direction and target for the fetch PC in the same cycle. It is trained by the resolved outcome from the execute-stage branch evaluator (`branch_taken`, target, original prediction). It also flags mispredicts and keeps saturating statistics counters.

---
 rtl/pkg_rv32_types.sv | 23 ++
 rtl/rv32_bp_sat_ctr.sv | 20 ++
 rtl/rv32_branch_predictor.sv | 95 +++++++++
 tb/tb_rv32_branch_predictor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pkg_rv32_types.sv
// Shared RV32 core types: XLEN, branch-predictor counter encoding, statistics width.
// Latency: none (types only); backpressure: none.
package pkg_rv32_types;

   localparam int XLEN   = 32;
   localparam int STAT_W = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   localparam bp_ctr_t BP_CTR_INIT  = WNT;
   localparam bp_ctr_t BP_CTR_ALLOC = WT;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + STAT_W'(1) : v;
   endfunction

endpackage

// File: rtl/rv32_bp_sat_ctr.sv
// 2-bit saturating direction counter next-state function.
// Latency: combinational; backpressure: none.
module rv32_bp_sat_ctr
   import pkg_rv32_types::*;
(
   input  bp_ctr_t ctr,
   input  logic    taken,
   output bp_ctr_t ctr_nxt
);

   always_comb begin
      ctr_nxt = ctr;
      if (taken) begin
         if (ctr != ST) ctr_nxt = bp_ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) ctr_nxt = bp_ctr_t'(ctr - 2'd1);
      end
   end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, mispredict flag and saturating stats.
// Latency: prediction combinational, training 1 edge; backpressure: none (update every cycle).
module rv32_branch_predictor
   import pkg_rv32_types::*;
#(
   parameter  int ENTRIES = 64,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   pred_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [XLEN-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [XLEN-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [XLEN-1:0]   upd_target,
   input  logic              upd_pred_taken,
   input  logic [XLEN-1:0]   upd_pred_target,
   input  logic              flush,
   output logic              mispredict,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int TAG_W = XLEN - IDX_W - 2;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      bp_ctr_t          ctr;
   } bp_entry_t;

   bp_entry_t bt_q [ENTRIES];

   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   bp_ctr_t          ctr_nxt;
   logic             unused_pc_lsbs;

   // Instructions are word aligned, so the low PC bits carry no information.
   assign unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

   assign pred_idx    = pred_pc[IDX_W+1:2];
   assign pred_hit    = bt_q[pred_idx].valid && (bt_q[pred_idx].tag == pred_pc[XLEN-1:IDX_W+2]);
   assign pred_taken  = pred_hit && bt_q[pred_idx].ctr[1];
   assign pred_target = pred_taken ? bt_q[pred_idx].target : pred_pc + XLEN'(4);

   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
   assign upd_hit = bt_q[upd_idx].valid && (bt_q[upd_idx].tag == upd_tag);

   assign mispredict = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

   rv32_bp_sat_ctr u_sat_ctr (
      .ctr     (bt_q[upd_idx].ctr),
      .taken   (upd_taken),
      .ctr_nxt (ctr_nxt)
   );

   // Flush takes priority over training so nothing allocated this edge survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++)
            bt_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_INIT};
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++)
            bt_q[i].valid <= 1'b0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            bt_q[upd_idx].ctr <= ctr_nxt;
            if (upd_taken) bt_q[upd_idx].target <= upd_target;
         end else if (upd_taken) begin
            bt_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: BP_CTR_ALLOC};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         stat_branches    <= stat_inc(stat_branches, upd_valid);
         stat_mispredicts <= stat_inc(stat_mispredicts, mispredict);
      end
   end

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Directed-vector bench for rv32_branch_predictor with a queue-based scoreboard.
module tb_rv32_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] pred_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        flush;
   logic        mispredict;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic        chk_mis;
      logic        mis;
      logic [31:0] br;
      logic [31:0] mp;
   } exp_t;

   exp_t sb_q[$];

   rv32_branch_predictor #(.ENTRIES(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .pred_pc          (pred_pc),
      .pred_hit         (pred_hit),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_target  (upd_pred_target),
      .flush            (flush),
      .mispredict       (mispredict),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the update edge.
   initial begin
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "pred_hit",    {31'd0, pred_hit},   {31'd0, e.hit});
            chk(e.name, "pred_taken",  {31'd0, pred_taken}, {31'd0, e.taken});
            chk(e.name, "pred_target", pred_target,         e.target);
            if (e.chk_mis) chk(e.name, "mispredict", {31'd0, mispredict}, {31'd0, e.mis});
            chk(e.name, "stat_branches",    stat_branches,    e.br);
            chk(e.name, "stat_mispredicts", stat_mispredicts, e.mp);
         end
      end
   end

   task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt, input logic fl);
      pred_pc         = pc;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_taken       = ut;
      upd_target      = utgt;
      upd_pred_taken  = upt;
      upd_pred_target = uptgt;
      flush           = fl;
   endtask

   task automatic push(input string nm, input logic hit, input logic tk, input logic [31:0] tgt,
                       input logic cm, input logic mis, input logic [31:0] br, input logic [31:0] mp);
      exp_t e;
      e.name = nm; e.hit = hit; e.taken = tk; e.target = tgt;
      e.chk_mis = cm; e.mis = mis; e.br = br; e.mp = mp;
      sb_q.push_back(e);
   endtask

   // One cycle: drive just after the rising edge, queue what the falling edge must show.
   task automatic cyc(input string nm, input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                      input logic fl, input logic hit, input logic tk, input logic [31:0] tgt,
                      input logic mis, input logic [31:0] br, input logic [31:0] mp);
      @(posedge clk);
      #1;
      drive(pc, uv, upc, ut, utgt, upt, uptgt, fl);
      push(nm, hit, tk, tgt, 1'b1, mis, br, mp);
   endtask

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      push("reset_hold", 1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 32'd0, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      //   name          pred_pc        uv  upd_pc         ut  upd_tgt       upt upd_ptgt      fl   hit tk  tgt           mis br           mp
      cyc("idle",        32'h100,       0,  32'h0,         0,  32'h0,        0,  32'h0,        0,   0,  0,  32'h104,      0,  32'd0,       32'd0);
      cyc("alloc",       32'h100,       1,  32'h100,       1,  32'h200,      0,  32'h104,      0,   0,  0,  32'h104,      1,  32'd0,       32'd0);
      cyc("after_alloc", 32'h100,       0,  32'h0,         0,  32'h0,        0,  32'h0,        0,   1,  1,  32'h200,      0,  32'd1,       32'd1);
      cyc("nt1",         32'h100,       1,  32'h100,       0,  32'h0,        1,  32'h200,      0,   1,  1,  32'h200,      1,  32'd1,       32'd1);
      cyc("nt2",         32'h100,       1,  32'h100,       0,  32'h0,        0,  32'h0,        0,   1,  0,  32'h104,      0,  32'd2,       32'd2);
      cyc("nt3",         32'h100,       1,  32'h100,       0,  32'h0,        0,  32'h0,        0,   1,  0,  32'h104,      0,  32'd3,       32'd2);
      cyc("no_underflow",32'h100,       1,  32'h100,       1,  32'h200,      0,  32'h104,      0,   1,  0,  32'h104,      1,  32'd4,       32'd2);
      cyc("alias_alloc", 32'h100,       1,  32'h200,       1,  32'h300,      0,  32'h204,      0,   1,  0,  32'h104,      1,  32'd5,       32'd3);
      cyc("alias_evict", 32'h100,       0,  32'h0,         0,  32'h0,        0,  32'h0,        0,   0,  0,  32'h104,      0,  32'd6,       32'd4);
      cyc("alias_hit",   32'h200,       1,  32'h200,       1,  32'h340,      1,  32'h300,      0,   1,  1,  32'h300,      1,  32'd6,       32'd4);
      cyc("tgt_retrain", 32'h200,       1,  32'h200,       1,  32'h340,      1,  32'h340,      0,   1,  1,  32'h340,      0,  32'd7,       32'd5);
      cyc("flush_upd",   32'h400,       1,  32'h400,       1,  32'h500,      0,  32'h404,      1,   0,  0,  32'h404,      1,  32'd8,       32'd5);
      cyc("flush_wins",  32'h400,       0,  32'h0,         0,  32'h0,        0,  32'h0,        0,   0,  0,  32'h404,      0,  32'd9,       32'd6);
      cyc("flush_clear", 32'h200,       0,  32'h0,         0,  32'h0,        0,  32'h0,        0,   0,  0,  32'h204,      0,  32'd9,       32'd6);
      cyc("pc_wrap",     32'hFFFF_FFFC, 0,  32'h0,         0,  32'h0,        0,  32'h0,        0,   0,  0,  32'h0,        0,  32'd9,       32'd6);

      // Preload both statistics just below saturation.
      @(posedge clk);
      #1;
      force dut.stat_branches    = 32'hFFFF_FFFE;
      force dut.stat_mispredicts = 32'hFFFF_FFFE;
      #1;
      release dut.stat_branches;
      release dut.stat_mispredicts;
      drive(32'h600, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0);
      push("sat_mp1", 1'b0, 1'b0, 32'h604, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE);

      cyc("sat_mp2",     32'h600,       1,  32'h600,       0,  32'h0,        1,  32'h700,      0,   0,  0,  32'h604,      1,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc("sat_mp3",     32'h600,       1,  32'h600,       0,  32'h0,        1,  32'h700,      0,   0,  0,  32'h604,      1,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc("sat_hold",    32'h800,       1,  32'h800,       1,  32'h900,      1,  32'h900,      0,   0,  0,  32'h804,      0,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc("pre_reset",   32'h800,       0,  32'h0,         0,  32'h0,        0,  32'h0,        0,   1,  1,  32'h900,      0,  32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Reset lands between edges while a taken update is being presented.
      @(posedge clk);
      #1;
      drive(32'h800, 1'b1, 32'h100, 1'b1, 32'hA00, 1'b0, 32'h104, 1'b0);
      #1 rst = 1'b1;
      push("mid_reset", 1'b0, 1'b0, 32'h804, 1'b0, 1'b0, 32'd0, 32'd0);

      @(posedge clk);
      #1 rst = 1'b0;
      drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      push("post_reset", 1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 32'd0, 32'd0);

      @(negedge clk);
      @(negedge clk);
      chk("drain", "pending", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
